spgd_perturb_seq: RTL and testbench

Sequencer that drives one SPGD iteration around the free-running Gaussian (CLT) noise generator.
- Captures N_CH consecutive signed noise samples into the external per-channel perturbation register file.
- Applies them to the actuators with + sign, waits a settle time, requests a metric measurement, then repeats with - sign.
- Signals iteration done.
- Sits between the CLT noise source and the actuator/metric-measurement logic.

---
 rtl/spgd_pkg.sv | 25 ++
 rtl/spgd_perturb_seq_if.sv | 25 ++
 rtl/spgd_settle_timer.sv | 29 ++
 rtl/spgd_perturb_seq.sv | 140 ++++++++++++++
 tb/tb_spgd_perturb_seq.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/spgd_pkg.sv
// Shared types and defaults for the SPGD perturbation sequencer slice.
package spgd_pkg;

   localparam int DEF_N_CH         = 32;
   localparam int DEF_ADDR_WIDTH   = 5;
   localparam int DEF_OUT_WIDTH    = 14;
   localparam int DEF_SETTLE_WIDTH = 16;
   localparam int DEF_ITER_WIDTH   = 16;

   localparam logic SIGN_POS = 1'b0;
   localparam logic SIGN_NEG = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_FILL       = 4'd1,
      ST_APPLY_POS  = 4'd2,
      ST_SETTLE_POS = 4'd3,
      ST_MEAS_POS   = 4'd4,
      ST_APPLY_NEG  = 4'd5,
      ST_SETTLE_NEG = 4'd6,
      ST_MEAS_NEG   = 4'd7,
      ST_DONE       = 4'd8
   } state_e;

endpackage

// File: rtl/spgd_perturb_seq_if.sv
// Perturbation register-file write bus plus actuator/metric handshake.
interface spgd_perturb_seq_if
   import spgd_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH
);
   logic                  pert_we;
   logic [ADDR_WIDTH-1:0] pert_addr;
   logic [OUT_WIDTH-1:0]  pert_data;
   logic                  pert_sign;
   logic                  apply;
   logic                  meas_req;
   logic                  meas_ack;

   modport master (
      output pert_we, pert_addr, pert_data, pert_sign, apply, meas_req,
      input  meas_ack
   );

   modport slave (
      input  pert_we, pert_addr, pert_data, pert_sign, apply, meas_req,
      output meas_ack
   );
endinterface

// File: rtl/spgd_settle_timer.sv
// Loadable settle down-counter; a zero load still waits one cycle.
module spgd_settle_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             busy,
   output logic             expire
);
   logic [WIDTH-1:0] count_r;

   // Count register: load with clamp, then decrement down to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= (load_value == '0) ? WIDTH'(1) : load_value;
      end else if (count_r != '0) begin
         count_r <= count_r - WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign busy   = (count_r != '0);
   assign expire = (count_r == WIDTH'(1));
endmodule

// File: rtl/spgd_perturb_seq.sv
// One SPGD iteration: capture N_CH scaled noise samples, then apply +delta and
// -delta, each followed by a settle wait and a metric measurement handshake.
module spgd_perturb_seq
   import spgd_pkg::*;
#(
   parameter int N_CH         = DEF_N_CH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
   parameter int SETTLE_WIDTH = DEF_SETTLE_WIDTH,
   parameter int ITER_WIDTH   = DEF_ITER_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [SETTLE_WIDTH-1:0] settle_cycles,
   input  logic [3:0]              amp_shift,
   input  logic [OUT_WIDTH-1:0]    rng_sample,
   output logic                    busy,
   output logic                    done,
   output logic [ITER_WIDTH-1:0]   iter_count,
   spgd_perturb_seq_if.master      bus
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(N_CH - 1);

   state_e                  state_r;
   logic [SETTLE_WIDTH-1:0] settle_r;
   logic [3:0]              amp_r;
   logic                    timer_load_s;
   logic                    timer_busy_s;
   logic                    timer_expire_s;

   // Shifts of OUT_WIDTH or more saturate to the sign (0 or -1).
   function automatic logic [OUT_WIDTH-1:0] scale_sample(
      input logic [OUT_WIDTH-1:0] sample,
      input logic [3:0]           shift
   );
      return OUT_WIDTH'($signed(sample) >>> shift);
   endfunction

   assign timer_load_s = (state_r == ST_APPLY_POS) || (state_r == ST_APPLY_NEG);

   spgd_settle_timer #(.WIDTH(SETTLE_WIDTH)) u_settle_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load_s),
      .load_value (settle_r),
      .busy       (timer_busy_s),
      .expire     (timer_expire_s)
   );

   // Sequencer FSM; every output is registered alongside the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         settle_r      <= '0;
         amp_r         <= 4'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         iter_count    <= '0;
         bus.pert_we   <= 1'b0;
         bus.pert_addr <= '0;
         bus.pert_data <= '0;
         bus.pert_sign <= SIGN_POS;
         bus.apply     <= 1'b0;
         bus.meas_req  <= 1'b0;
      end else begin
         bus.pert_we <= 1'b0;
         bus.apply   <= 1'b0;
         done        <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r       <= ST_FILL;
                  busy          <= 1'b1;
                  settle_r      <= settle_cycles;
                  amp_r         <= amp_shift;
                  bus.pert_we   <= 1'b1;
                  bus.pert_addr <= '0;
                  bus.pert_data <= scale_sample(rng_sample, amp_shift);
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_FILL: begin
               if (bus.pert_addr == ADDR_LAST) begin
                  state_r       <= ST_APPLY_POS;
                  bus.apply     <= 1'b1;
                  bus.pert_sign <= SIGN_POS;
               end else begin
                  bus.pert_we   <= 1'b1;
                  bus.pert_addr <= bus.pert_addr + ADDR_WIDTH'(1);
                  bus.pert_data <= scale_sample(rng_sample, amp_r);
               end
            end
            ST_APPLY_POS: state_r <= ST_SETTLE_POS;
            ST_SETTLE_POS: begin
               // An idle timer also exits so a corrupted count cannot hang us.
               if (timer_expire_s || !timer_busy_s) begin
                  state_r      <= ST_MEAS_POS;
                  bus.meas_req <= 1'b1;
               end
            end
            ST_MEAS_POS: begin
               if (bus.meas_ack) begin
                  state_r       <= ST_APPLY_NEG;
                  bus.meas_req  <= 1'b0;
                  bus.apply     <= 1'b1;
                  bus.pert_sign <= SIGN_NEG;
               end
            end
            ST_APPLY_NEG: state_r <= ST_SETTLE_NEG;
            ST_SETTLE_NEG: begin
               if (timer_expire_s || !timer_busy_s) begin
                  state_r      <= ST_MEAS_NEG;
                  bus.meas_req <= 1'b1;
               end
            end
            ST_MEAS_NEG: begin
               if (bus.meas_ack) begin
                  state_r       <= ST_DONE;
                  bus.meas_req  <= 1'b0;
                  bus.pert_sign <= SIGN_POS;
                  done          <= 1'b1;
                  iter_count    <= iter_count + ITER_WIDTH'(1);
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r       <= ST_IDLE;
               busy          <= 1'b0;
               bus.meas_req  <= 1'b0;
               bus.pert_sign <= SIGN_POS;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spgd_perturb_seq.sv
// Self-checking bench: each iteration's output trace is predicted from a
// timeline (fill, apply, settle, measure offsets) and compared cycle by cycle.
module tb_spgd_perturb_seq;
   localparam int N_CH = 4;
   localparam int AW   = 2;
   localparam int OW   = 14;
   localparam int SW   = 16;
   localparam int IW   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [SW-1:0] settle_cycles;
   logic [3:0]    amp_shift;
   logic [OW-1:0] rng_sample;
   logic          busy;
   logic          done;
   logic [IW-1:0] iter_count;

   int n_vec = 0;
   int n_err = 0;
   int exp_iter = 0;
   int rng_plan[$];

   spgd_perturb_seq_if #(.ADDR_WIDTH(AW), .OUT_WIDTH(OW)) bus ();

   spgd_perturb_seq #(
      .N_CH(N_CH), .ADDR_WIDTH(AW), .OUT_WIDTH(OW), .SETTLE_WIDTH(SW), .ITER_WIDTH(IW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .settle_cycles(settle_cycles),
      .amp_shift(amp_shift), .rng_sample(rng_sample), .busy(busy), .done(done),
      .iter_count(iter_count), .bus(bus)
   );

   always #5 clk = ~clk;

   // Arithmetic right shift is floor division by 2^sh.
   function automatic int scale_ref(input int v, input int sh);
      int dv;
      int q;
      dv = 1 << sh;
      q = v / dv;
      if (v < 0 && q * dv != v) q = q - 1;
      return q;
   endfunction

   // One full iteration with start sampled at the end of interval 0.
   task automatic run_iter(input int s, input int dpos, input int dneg, input int amp, input bit noise);
      int sp, a1, m1, a2, m2, d, v;
      int rv[$];
      bit in_meas, e_we, e_apply, e_req, e_busy, e_done, e_sign;
      int e_iter;
      sp = (s == 0) ? 1 : s;
      a1 = N_CH + 1;
      m1 = a1 + sp + 1;
      a2 = m1 + dpos + 1;
      m2 = a2 + sp + 1;
      d  = m2 + dneg + 1;
      for (int j = 0; j <= d; j++) begin
         in_meas = (j >= m1 && j <= m1 + dpos) || (j >= m2 && j <= m2 + dneg);
         if (j == 0) begin
            start = 1'b1;
            settle_cycles = SW'(s);
            amp_shift = 4'(amp);
         end else begin
            start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            settle_cycles = SW'($urandom);
            amp_shift = 4'($urandom);
         end
         if (in_meas) bus.meas_ack = (j == m1 + dpos) || (j == m2 + dneg);
         else bus.meas_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
         if (rng_plan.size() > 0) v = rng_plan.pop_front();
         else v = int'($urandom_range(16383, 0)) - 8192;
         rng_sample = OW'(v);
         rv.push_back(v);
         @(negedge clk);
         e_we    = (j >= 1 && j <= N_CH);
         e_apply = (j == a1 || j == a2);
         e_req   = in_meas;
         e_busy  = (j >= 1);
         e_done  = (j == d);
         e_sign  = (j >= a2 && j < d);
         e_iter  = (j == d) ? (exp_iter + 1) % (1 << IW) : exp_iter;
         n_vec += 7;
         if (bus.pert_we !== e_we) begin n_err++; $display("FAIL pert_we j=%0d got %0b want %0b", j, bus.pert_we, e_we); end
         if (bus.apply !== e_apply) begin n_err++; $display("FAIL apply j=%0d got %0b want %0b", j, bus.apply, e_apply); end
         if (bus.meas_req !== e_req) begin n_err++; $display("FAIL meas_req j=%0d got %0b want %0b", j, bus.meas_req, e_req); end
         if (busy !== e_busy) begin n_err++; $display("FAIL busy j=%0d got %0b want %0b", j, busy, e_busy); end
         if (done !== e_done) begin n_err++; $display("FAIL done j=%0d got %0b want %0b", j, done, e_done); end
         if (bus.pert_sign !== e_sign) begin n_err++; $display("FAIL pert_sign j=%0d got %0b want %0b", j, bus.pert_sign, e_sign); end
         if (iter_count !== IW'(e_iter)) begin n_err++; $display("FAIL iter_count j=%0d got %0d want %0d", j, iter_count, e_iter); end
         if (e_we) begin
            n_vec += 2;
            if (bus.pert_addr !== AW'(j - 1)) begin n_err++; $display("FAIL pert_addr j=%0d got %0d want %0d", j, bus.pert_addr, j - 1); end
            if (bus.pert_data !== OW'(scale_ref(rv[j - 1], amp))) begin
               n_err++;
               $display("FAIL pert_data j=%0d got %0h want %0h", j, bus.pert_data, OW'(scale_ref(rv[j - 1], amp)));
            end
         end
         @(posedge clk); #1;
      end
      exp_iter = (exp_iter + 1) % (1 << IW);
      start = 1'b0;
      bus.meas_ack = 1'b0;
   endtask

   task automatic test_reset();
      for (int r = 0; r < 3; r++) begin
         if (r == 2) rst = 1'b0;
         @(negedge clk);
         n_vec += 2;
         if (busy !== 1'b0) begin n_err++; $display("FAIL init_busy got %0b want 0", busy); end
         if (iter_count !== '0) begin n_err++; $display("FAIL init_iter got %0d want 0", iter_count); end
         @(posedge clk); #1;
      end
      run_iter(2, 1, 1, 3, 1'b0);
      start = 1'b1; settle_cycles = SW'(2); amp_shift = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      rst = 1'b1;
      for (int r = 0; r < 4; r++) begin
         if (r == 3) rst = 1'b0;
         @(negedge clk);
         if (r > 0) begin
            n_vec += 5;
            if ({bus.pert_we, bus.apply, bus.meas_req, bus.pert_sign} !== 4'b0) begin
               n_err++; $display("FAIL rst_strobes r=%0d got %b want 0000", r, {bus.pert_we, bus.apply, bus.meas_req, bus.pert_sign});
            end
            if ({bus.pert_addr, bus.pert_data} !== '0) begin n_err++; $display("FAIL rst_bus r=%0d got %0h want 0", r, {bus.pert_addr, bus.pert_data}); end
            if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy r=%0d got %0b want 0", r, busy); end
            if (done !== 1'b0) begin n_err++; $display("FAIL rst_done r=%0d got %0b want 0", r, done); end
            if (iter_count !== '0) begin n_err++; $display("FAIL rst_iter r=%0d got %0d want 0", r, iter_count); end
         end
         @(posedge clk); #1;
      end
      exp_iter = 0;
      run_iter(1, 0, 2, 0, 1'b0);
   endtask

   task automatic test_ramp();
      repeat (2) begin @(posedge clk); #1; end
      for (int i = 0; i < 40; i++) rng_plan.push_back(10 + i);
      run_iter(3, 0, 0, 0, 1'b0);
      rng_plan.delete();
   endtask

   task automatic test_scaling();
      rng_plan = '{-8192, 5, -1, 7};
      run_iter(1, 0, 0, 2, 1'b0);
      rng_plan = '{100, -100, 8191, -8192};
      run_iter(2, 1, 0, 15, 1'b0);
      rng_plan = '{8191, -8192, -3, 3};
      run_iter(1, 0, 1, 14, 1'b0);
   endtask

   task automatic test_settle_zero();
      run_iter(0, 0, 0, 1, 1'b0);
      run_iter(0, 2, 1, int'($urandom_range(13, 0)), 1'b1);
   endtask

   task automatic test_ack_delay_noise();
      run_iter(int'($urandom_range(5, 1)), 10, 10, int'($urandom_range(15, 0)), 1'b1);
      run_iter(int'($urandom_range(4, 0)), 3, 7, int'($urandom_range(15, 0)), 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++)
         run_iter(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                  int'($urandom_range(15, 0)), 1'b1);
   endtask

   task automatic test_wrap();
      repeat (3) begin @(posedge clk); #1; end
      for (int i = 0; i < 17; i++)
         run_iter(int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                  int'($urandom_range(15, 0)), 1'(i % 2));
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      settle_cycles = '0;
      amp_shift = 4'd0;
      rng_sample = '0;
      bus.meas_ack = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_ramp();
      test_scaling();
      test_settle_zero();
      test_ack_delay_noise();
      test_back_to_back();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
